// File: rtl/cordic_lin_mac.sv
// ============================================================================
//  Module      : cordic_lin_mac
//  Description : Linear-mode CORDIC multiply-accumulate, y_out = y_in + x_in*z_in,
//                one iteration per clock with a valid/ready handshake each side.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cordic_lin_mac #(
    parameter int WIDTH = 15,
    parameter int FRAC  = 12,
    parameter int ITER  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   x_in,
    input  logic [WIDTH:0]   z_in,
    input  logic [WIDTH:0]   y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y_out,
    output logic [WIDTH:0]   z_res
);

    localparam int             c_IW  = $clog2(ITER + 1);
    localparam logic [WIDTH:0] c_ONE = (WIDTH + 1)'(1) << FRAC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_live;
    logic [c_IW-1:0] r_i;
    logic [WIDTH:0]  r_x;
    logic [WIDTH:0]  r_y;
    logic [WIDTH:0]  r_z;

    logic            w_accept;
    logic            w_last;
    logic            w_dpos;
    logic [WIDTH:0]  w_xsh;
    logic [WIDTH:0]  w_step;
    logic [WIDTH:0]  w_ynext;
    logic [WIDTH:0]  w_znext;

    // Sum is formed one bit wider; the true sign replaces bit WIDTH (wrap, no saturation).
    function automatic logic [WIDTH:0] f_addsub(input logic [WIDTH:0] a,
                                                input logic [WIDTH:0] b,
                                                input logic           sub);
        logic [WIDTH+1:0] s;
        if (sub)
            s = {a[WIDTH], a} - {b[WIDTH], b};
        else
            s = {a[WIDTH], a} + {b[WIDTH], b};
        return {s[WIDTH+1], s[WIDTH-1:0]};
    endfunction

    assign w_accept = (r_state == S_IDLE) && r_live && in_valid;
    assign w_last   = (r_i == c_IW'(ITER - 1));
    assign w_dpos   = ~r_z[WIDTH];
    assign w_xsh    = $signed(r_x) >>> r_i;
    assign w_step   = c_ONE >> r_i;
    assign w_ynext  = f_addsub(r_y, w_xsh,  ~w_dpos);
    assign w_znext  = f_addsub(r_z, w_step,  w_dpos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = r_live;
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_live keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_i    <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_x <= x_in;
                r_y <= y_in;
                r_z <= z_in;
                r_i <= '0;
            end else if (r_state == S_RUN) begin
                r_y <= w_ynext;
                r_z <= w_znext;
                r_i <= r_i + c_IW'(1);
            end
        end
    end

    assign y_out = r_y;
    assign z_res = r_z;

endmodule

`default_nettype wire

// File: tb/tb_cordic_lin_mac.sv
// ============================================================================
//  Module      : tb_cordic_lin_mac
//  Description : Directed self-checking bench for cordic_lin_mac.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cordic_lin_mac;

    localparam int WIDTH = 15;
    localparam int FRAC  = 12;
    localparam int ITER  = 12;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] x_in      = '0;
    logic [15:0] z_in      = '0;
    logic [15:0] y_in      = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] y_out;
    logic [15:0] z_res;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cordic_lin_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .z_in      (z_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .z_res     (z_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic issue(input logic [15:0] x, input logic [15:0] z, input logic [15:0] y);
        x_in     = x;
        z_in     = z;
        y_in     = y;
        in_valid = 1'b1;
        chk("in_ready_before_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("in_ready_in_run", in_ready, 0);
    endtask

    // Exact integer sum, then keep its sign over the low 15 bits.
    function automatic int wrap(input int s);
        logic [15:0] r;
        r = {s[31], s[14:0]};
        return int'($signed(r));
    endfunction

    task automatic model(input logic [15:0] x, input logic [15:0] z, input logic [15:0] y,
                         output logic [15:0] ye, output logic [15:0] ze);
        int xi, zi, yi, xs, c;
        xi = int'($signed(x));
        zi = int'($signed(z));
        yi = int'($signed(y));
        for (int i = 0; i < ITER; i++) begin
            xs = xi >>> i;
            c  = (1 << FRAC) >> i;
            if (zi >= 0) begin
                yi = wrap(yi + xs);
                zi = wrap(zi - c);
            end else begin
                yi = wrap(yi - xs);
                zi = wrap(zi + c);
            end
        end
        ye = yi[15:0];
        ze = zi[15:0];
    endtask

    logic [15:0] vx [5];
    logic [15:0] vz [5];
    logic [15:0] vy [5];

    initial begin
        int          n;
        int          acc_prev;
        logic [15:0] ye, ze;

        // Reset behaviour
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 16'h0000);
        chk("rst_z_res", z_res, 16'h0000);
        in_valid = 1'b1;
        step();
        step();
        chk("rst_hold_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        chk("release_in_ready_low", in_ready, 0);
        step();
        chk("release_in_ready_high", in_ready, 1);

        // 1.0 * 0.5 + 0
        out_ready = 1'b1;
        issue(16'h1000, 16'h0800, 16'h0000);
        wait_out(n);
        chk("mul_half_latency", n, ITER);
        chk("mul_half_y", y_out, 16'h0802);
        chk("mul_half_z", z_res, 16'hFFFE);
        step();
        chk("mul_half_idle_valid", out_valid, 0);
        chk("mul_half_idle_ready", in_ready, 1);
        chk("mul_half_idle_y", y_out, 16'h0802);

        // -1.0 * 1.5 + 0.25 with back-pressure
        out_ready = 1'b0;
        issue(16'hF000, 16'h1800, 16'h0400);
        wait_out(n);
        chk("neg_latency", n, ITER);
        chk("neg_y", y_out, 16'hEBFE);
        chk("neg_z", z_res, 16'hFFFE);
        for (int k = 0; k < 20; k++) begin
            in_valid = k[0];
            x_in     = 16'h1234 + 16'(k);
            z_in     = 16'h0321;
            y_in     = 16'h5555;
            step();
            chk("stall_valid", out_valid, 1);
            chk("stall_y", y_out, 16'hEBFE);
            chk("stall_z", z_res, 16'hFFFE);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("stall_release_valid", out_valid, 0);
        chk("stall_release_ready", in_ready, 1);

        // Wrap corner
        issue(16'h7FFF, 16'h1FFF, 16'h7000);
        wait_out(n);
        model(16'h7FFF, 16'h1FFF, 16'h7000, ye, ze);
        chk("wrap_latency", n, ITER);
        chk("wrap_y_hand", y_out, 16'h6FE4);
        chk("wrap_z_hand", z_res, 16'h0001);
        chk("wrap_y_model", y_out, ye);
        chk("wrap_z_model", z_res, ze);
        step();

        // Back-to-back with in_valid held high; inputs change during RUN
        vx[0] = 16'h1000; vz[0] = 16'h0800; vy[0] = 16'h0000;
        vx[1] = 16'hF000; vz[1] = 16'h1800; vy[1] = 16'h0400;
        vx[2] = 16'h0C00; vz[2] = 16'hF400; vy[2] = 16'h0200;
        vx[3] = 16'h8000; vz[3] = 16'h1000; vy[3] = 16'h0000;
        vx[4] = 16'h4000; vz[4] = 16'hE001; vy[4] = 16'h7FFF;
        x_in = vx[0]; z_in = vz[0]; y_in = vy[0];
        in_valid = 1'b1;
        acc_prev = 0;
        for (int k = 0; k < 5; k++) begin
            chk("b2b_ready", in_ready, 1);
            step();
            if (k > 0) chk("b2b_interval", cyc - acc_prev, ITER + 2);
            acc_prev = cyc;
            if (k < 4) begin
                x_in = vx[k+1]; z_in = vz[k+1]; y_in = vy[k+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_out(n);
            model(vx[k], vz[k], vy[k], ye, ze);
            chk("b2b_latency", n, ITER);
            chk("b2b_y", y_out, ye);
            chk("b2b_z", z_res, ze);
            step();
        end

        // Reset in the middle of RUN
        issue(16'h1000, 16'h0800, 16'h0000);
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        #1;
        chk("abort_y", y_out, 16'h0000);
        chk("abort_z", z_res, 16'h0000);
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 0);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("abort_no_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        step();
        chk("abort_release_ready", in_ready, 1);
        issue(16'h1000, 16'h0800, 16'h0000);
        wait_out(n);
        chk("after_abort_latency", n, ITER);
        chk("after_abort_y", y_out, 16'h0802);
        chk("after_abort_z", z_res, 16'hFFFE);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
